// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the loopback 8N1 UART (uart_interface and
// uart_rx): FSM state enums, default clock/baud values, bit-period helper
// and counter widths.
// -----------------------------------------------------------------------------
package uart_pkg;

   // Default system clock and serial rate.
   localparam int DEFAULT_CLK_FREQ  = 50_000_000;
   localparam int DEFAULT_BAUD_RATE = 115_200;

   // Width of the data-bit index (8 data bits -> 0..7).
   localparam int BIT_IDX_W = 3;

   // Width of the per-bit cycle counter; covers bit periods up to 65535 clocks.
   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   // Clocks per serial bit; integer division truncates.
   function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage : uart_pkg

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 receiver: 2-flop synchronizer on rx_in followed by a receive FSM that
// validates the start bit at its centre, samples 8 data bits LSB first at
// bit centres and checks the stop bit.
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-high reset
//   rx_in     serial input line (idle high)
//   RxData    last correctly framed byte, held between frames
//   valid_rx  one-cycle pulse when RxData is updated
// -----------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = clks_per_bit(DEFAULT_CLK_FREQ, DEFAULT_BAUD_RATE)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_in,
   output logic [7:0] RxData,
   output logic       valid_rx
);

   localparam logic [CNT_W-1:0]     BIT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]     HALF_LAST    = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BIT_IDX_W-1:0] BIT_IDX_LAST = {BIT_IDX_W{1'b1}};

   logic                 sync1_r;
   logic                 sync2_r;
   rx_state_t            rx_state_r;
   rx_state_t            rx_state_s;
   logic [CNT_W-1:0]     cnt_r;
   logic [CNT_W-1:0]     cnt_s;
   logic [BIT_IDX_W-1:0] bit_idx_r;
   logic [BIT_IDX_W-1:0] bit_idx_s;
   logic [7:0]           shift_r;
   logic [7:0]           shift_s;
   logic [7:0]           data_r;
   logic [7:0]           data_s;
   logic                 valid_r;
   logic                 valid_s;

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= rx_in;
         sync2_r <= sync1_r;
      end
   end

   // Receive FSM state and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_state_r <= RX_IDLE;
         cnt_r      <= {CNT_W{1'b0}};
         bit_idx_r  <= {BIT_IDX_W{1'b0}};
         shift_r    <= 8'h00;
         data_r     <= 8'h00;
         valid_r    <= 1'b0;
      end else begin
         rx_state_r <= rx_state_s;
         cnt_r      <= cnt_s;
         bit_idx_r  <= bit_idx_s;
         shift_r    <= shift_s;
         data_r     <= data_s;
         valid_r    <= valid_s;
      end
   end

   // Receive FSM next-state and datapath logic.
   always_comb begin
      rx_state_s = rx_state_r;
      cnt_s      = cnt_r;
      bit_idx_s  = bit_idx_r;
      shift_s    = shift_r;
      data_s     = data_r;
      valid_s    = 1'b0;
      case (rx_state_r)
         RX_IDLE: begin
            cnt_s     = {CNT_W{1'b0}};
            bit_idx_s = {BIT_IDX_W{1'b0}};
            if (sync2_r == 1'b0) begin
               rx_state_s = RX_START;
            end else begin
               rx_state_s = RX_IDLE;
            end
         end
         RX_START: begin
            // Centre of the start bit: a high here means the edge was a glitch.
            if (cnt_r == HALF_LAST) begin
               cnt_s = {CNT_W{1'b0}};
               if (sync2_r == 1'b0) begin
                  rx_state_s = RX_DATA;
               end else begin
                  rx_state_s = RX_IDLE;
               end
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         RX_DATA: begin
            // Counting a full bit period from a centre lands on the next centre.
            if (cnt_r == BIT_LAST) begin
               cnt_s   = {CNT_W{1'b0}};
               shift_s = {sync2_r, shift_r[7:1]};
               if (bit_idx_r == BIT_IDX_LAST) begin
                  bit_idx_s  = {BIT_IDX_W{1'b0}};
                  rx_state_s = RX_STOP;
               end else begin
                  bit_idx_s = bit_idx_r + BIT_IDX_W'(1);
               end
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         RX_STOP: begin
            if (cnt_r == BIT_LAST) begin
               cnt_s      = {CNT_W{1'b0}};
               rx_state_s = RX_IDLE;
               // A low stop bit is a framing error: drop the byte silently.
               if (sync2_r == 1'b1) begin
                  data_s  = shift_r;
                  valid_s = 1'b1;
               end else begin
                  data_s  = data_r;
                  valid_s = 1'b0;
               end
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         default: begin
            rx_state_s = RX_IDLE;
            cnt_s      = {CNT_W{1'b0}};
            bit_idx_s  = {BIT_IDX_W{1'b0}};
         end
      endcase
   end

   assign RxData   = data_r;
   assign valid_rx = valid_r;

endmodule : uart_rx

// File: rtl/uart_interface.sv
// -----------------------------------------------------------------------------
// uart_interface
// 8N1 UART transmitter with its serial output looped back into an internal
// receiver (uart_rx).
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-high reset
//   transmit  send request, sampled at posedge; ignored while busy
//   TxData    byte to send, captured in the accept cycle
//   TxD       serial line, idle high (registered)
//   busy      transmitter occupied (registered)
//   RxData    last correctly received byte
//   valid_rx  one-cycle pulse when RxData is updated
// -----------------------------------------------------------------------------
module uart_interface
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = DEFAULT_CLK_FREQ,
   parameter int BAUD_RATE = DEFAULT_BAUD_RATE
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       transmit,
   input  logic [7:0] TxData,
   output logic       TxD,
   output logic       busy,
   output logic [7:0] RxData,
   output logic       valid_rx
);

   localparam int                   CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam logic [CNT_W-1:0]     BIT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_IDX_W-1:0] BIT_IDX_LAST = {BIT_IDX_W{1'b1}};

   tx_state_t            tx_state_r;
   tx_state_t            tx_state_s;
   logic [CNT_W-1:0]     cnt_r;
   logic [CNT_W-1:0]     cnt_s;
   logic [BIT_IDX_W-1:0] bit_idx_r;
   logic [BIT_IDX_W-1:0] bit_idx_s;
   logic [7:0]           shift_r;
   logic [7:0]           shift_s;
   logic                 txd_r;
   logic                 txd_s;
   logic                 busy_r;
   logic                 busy_s;
   logic                 rx_line_s;

   // Transmit FSM state, datapath and registered line/busy outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state_r <= TX_IDLE;
         cnt_r      <= {CNT_W{1'b0}};
         bit_idx_r  <= {BIT_IDX_W{1'b0}};
         shift_r    <= 8'h00;
         txd_r      <= 1'b1;
         busy_r     <= 1'b0;
      end else begin
         tx_state_r <= tx_state_s;
         cnt_r      <= cnt_s;
         bit_idx_r  <= bit_idx_s;
         shift_r    <= shift_s;
         txd_r      <= txd_s;
         busy_r     <= busy_s;
      end
   end

   // Transmit FSM next-state logic; the next line level is computed here so
   // TxD changes exactly on bit boundaries from a flop.
   always_comb begin
      tx_state_s = tx_state_r;
      cnt_s      = cnt_r;
      bit_idx_s  = bit_idx_r;
      shift_s    = shift_r;
      txd_s      = txd_r;
      busy_s     = busy_r;
      case (tx_state_r)
         TX_IDLE: begin
            cnt_s     = {CNT_W{1'b0}};
            bit_idx_s = {BIT_IDX_W{1'b0}};
            if (transmit) begin
               tx_state_s = TX_START;
               shift_s    = TxData;
               txd_s      = 1'b0;
               busy_s     = 1'b1;
            end else begin
               tx_state_s = TX_IDLE;
               txd_s      = 1'b1;
               busy_s     = 1'b0;
            end
         end
         TX_START: begin
            if (cnt_r == BIT_LAST) begin
               cnt_s      = {CNT_W{1'b0}};
               tx_state_s = TX_DATA;
               txd_s      = shift_r[0];
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         TX_DATA: begin
            // The shift register always presents the current bit at [0].
            if (cnt_r == BIT_LAST) begin
               cnt_s = {CNT_W{1'b0}};
               if (bit_idx_r == BIT_IDX_LAST) begin
                  bit_idx_s  = {BIT_IDX_W{1'b0}};
                  tx_state_s = TX_STOP;
                  txd_s      = 1'b1;
               end else begin
                  bit_idx_s = bit_idx_r + BIT_IDX_W'(1);
                  shift_s   = {1'b0, shift_r[7:1]};
                  txd_s     = shift_r[1];
               end
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         TX_STOP: begin
            if (cnt_r == BIT_LAST) begin
               cnt_s      = {CNT_W{1'b0}};
               tx_state_s = TX_IDLE;
               txd_s      = 1'b1;
               busy_s     = 1'b0;
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         default: begin
            tx_state_s = TX_IDLE;
            cnt_s      = {CNT_W{1'b0}};
            bit_idx_s  = {BIT_IDX_W{1'b0}};
            txd_s      = 1'b1;
            busy_s     = 1'b0;
         end
      endcase
   end

   assign TxD       = txd_r;
   assign busy      = busy_r;

   // Internal loopback; kept as a named net so an external RxD can replace it.
   assign rx_line_s = txd_r;

   uart_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clk      (clk),
      .reset    (reset),
      .rx_in    (rx_line_s),
      .RxData   (RxData),
      .valid_rx (valid_rx)
   );

endmodule : uart_interface

// File: tb/tb_uart_interface.sv
module tb_uart_interface;

   localparam int CPB        = 434;
   localparam int FRAME_CYC  = 10 * CPB;
   localparam int NOMINAL_LAT = 2 + CPB / 2 + 9 * CPB;

   logic       clk = 1'b0;
   logic       reset;
   logic       transmit;
   logic [7:0] TxData;
   logic       TxD;
   logic       busy;
   logic [7:0] RxData;
   logic       valid_rx;

   int checks   = 0;
   int failures = 0;

   int          cyc = 0;
   logic [7:0]  rx_q[$];
   int          rx_t[$];
   int          wide_cnt = 0;
   logic        prev_valid = 1'b0;
   int          last_rx_cyc = 0;
   int          accept_cyc = 0;

   uart_interface dut (
      .clk      (clk),
      .reset    (reset),
      .transmit (transmit),
      .TxData   (TxData),
      .TxD      (TxD),
      .busy     (busy),
      .RxData   (RxData),
      .valid_rx (valid_rx)
   );

   always #10 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   // Record every received byte and its cycle; flag any pulse longer than one cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_valid = 1'b0;
         end else begin
            if (valid_rx === 1'b1) begin
               rx_q.push_back(RxData);
               rx_t.push_back(cyc);
               if (prev_valid) wide_cnt = wide_cnt + 1;
            end
            prev_valid = (valid_rx === 1'b1);
         end
      end
   end

   // Issues one byte (waiting for idle first), checks the serial frame against
   // the 8N1 bit pattern, busy duration, received byte and latency.
   // inject_at > 0 pulses transmit with FF that many cycles into the frame.
   task automatic send_and_check(input logic [7:0] b, input int inject_at);
      logic [9:0] obs;
      logic [9:0] expv;
      int waited;
      int fall_n;
      int lat;
      expv = {1'b1, b, 1'b0};
      waited = 0;
      while (busy !== 1'b0 && waited < 2 * FRAME_CYC) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (waited >= 2 * FRAME_CYC) begin
         failures++;
         $display("FAIL idle_wait: busy=%b still high after %0d cycles", busy, waited);
      end
      transmit = 1'b1;
      TxData   = b;
      @(negedge clk);
      transmit   = 1'b0;
      accept_cyc = cyc;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL busy_rise: busy=%b expected 1 for byte %02h", busy, b);
      end
      obs    = 10'h000;
      fall_n = 0;
      for (int n = 1; n <= 2 * FRAME_CYC && fall_n == 0; n++) begin
         @(negedge clk);
         if (inject_at > 0 && n == inject_at) begin
            transmit = 1'b1;
            TxData   = 8'hFF;
         end else begin
            transmit = 1'b0;
         end
         if (n >= CPB / 2 && ((n - CPB / 2) % CPB) == 0 && ((n - CPB / 2) / CPB) < 10)
            obs[(n - CPB / 2) / CPB] = TxD;
         if (busy === 1'b0) fall_n = n;
      end
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL frame_bits: byte %02h got %b expected %b", b, obs, expv);
      end
      checks++;
      if (fall_n != FRAME_CYC) begin
         failures++;
         $display("FAIL busy_len: byte %02h busy fell after %0d cycles expected %0d", b, fall_n, FRAME_CYC);
      end
      checks++;
      if (rx_q.size() != 1) begin
         failures++;
         $display("FAIL rx_count: byte %02h got %0d pulses expected 1", b, rx_q.size());
      end else begin
         lat = rx_t[0] - accept_cyc;
         last_rx_cyc = rx_t[0];
         checks++;
         if (rx_q[0] !== b) begin
            failures++;
            $display("FAIL rx_data: got %02h expected %02h", rx_q[0], b);
         end
         checks++;
         if (lat < NOMINAL_LAT - 1 || lat > NOMINAL_LAT + 1) begin
            failures++;
            $display("FAIL rx_latency: byte %02h got %0d expected %0d+-1", b, lat, NOMINAL_LAT);
         end
      end
      rx_q.delete();
      rx_t.delete();
   endtask

   task automatic test_reset();
      int bad;
      transmit = 1'b0;
      TxData   = 8'h00;
      reset    = 1'b0;
      #5 reset = 1'b1;
      #50;
      checks++;
      if (TxD !== 1'b1 || busy !== 1'b0 || valid_rx !== 1'b0 || RxData !== 8'h00) begin
         failures++;
         $display("FAIL reset_values: TxD=%b busy=%b valid_rx=%b RxData=%02h expected 1 0 0 00",
                  TxD, busy, valid_rx, RxData);
      end
      #50;
      @(negedge clk);
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (TxD !== 1'b1 || busy !== 1'b0 || valid_rx !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0 || rx_q.size() != 0) begin
         failures++;
         $display("FAIL reset_quiet: %0d active cycles, %0d pulses, expected 0 0", bad, rx_q.size());
      end
   endtask

   task automatic test_single();
      send_and_check(8'h53, 0);
   endtask

   task automatic test_back_to_back();
      logic [7:0] msg [6];
      int first_cyc;
      int prev_cyc;
      int gap;
      msg = '{8'h53, 8'h41, 8'h55, 8'h52, 8'h41, 8'h56};
      first_cyc = 0;
      prev_cyc  = 0;
      for (int i = 0; i < 6; i++) begin
         send_and_check(msg[i], 0);
         if (i == 0) begin
            first_cyc = accept_cyc;
         end else begin
            gap = last_rx_cyc - prev_cyc;
            checks++;
            if (gap < FRAME_CYC - 5 || gap > FRAME_CYC + 5) begin
               failures++;
               $display("FAIL b2b_spacing: pulse %0d gap %0d cycles expected about %0d", i, gap, FRAME_CYC);
            end
         end
         prev_cyc = last_rx_cyc;
      end
      checks++;
      if ((last_rx_cyc - first_cyc) * 20 > 600_000) begin
         failures++;
         $display("FAIL b2b_total: %0d ns expected under 600000", (last_rx_cyc - first_cyc) * 20);
      end
   endtask

   task automatic test_ignore_busy();
      logic [7:0] b;
      int bad;
      b = 8'($urandom_range(0, 254));
      send_and_check(b, 2000);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy !== 1'b0 || TxD !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0 || rx_q.size() != 0) begin
         failures++;
         $display("FAIL ignore_busy: %0d active cycles, %0d extra pulses after frame, expected 0 0", bad, rx_q.size());
      end
   endtask

   task automatic test_reset_abort();
      transmit = 1'b1;
      TxData   = 8'hA5;
      @(negedge clk);
      transmit = 1'b0;
      repeat (3 * CPB) @(negedge clk);
      #3 reset = 1'b1;
      #1;
      checks++;
      if (TxD !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_immediate: TxD=%b busy=%b expected 1 0", TxD, busy);
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      rx_q.delete();
      rx_t.delete();
      repeat (12 * CPB) @(negedge clk);
      checks++;
      if (rx_q.size() != 0 || RxData !== 8'h00 || TxD !== 1'b1) begin
         failures++;
         $display("FAIL abort_no_rx: pulses=%0d RxData=%02h TxD=%b expected 0 00 1", rx_q.size(), RxData, TxD);
      end
      send_and_check(8'h3C, 0);
   endtask

   task automatic test_glitch();
      logic [7:0] held;
      held = RxData;
      @(negedge clk);
      force dut.rx_line_s = 1'b0;
      @(negedge clk);
      release dut.rx_line_s;
      repeat (2 * CPB) @(negedge clk);
      checks++;
      if (rx_q.size() != 0 || RxData !== held) begin
         failures++;
         $display("FAIL glitch_reject: pulses=%0d RxData=%02h expected 0 %02h", rx_q.size(), RxData, held);
      end
      rx_q.delete();
      rx_t.delete();
   endtask

   task automatic test_random();
      for (int i = 0; i < 3; i++) begin
         send_and_check(8'($urandom_range(0, 255)), 0);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_ignore_busy();
      test_reset_abort();
      test_glitch();
      test_random();
      checks++;
      if (wide_cnt != 0) begin
         failures++;
         $display("FAIL pulse_width: %0d pulses wider than one cycle, expected 0", wide_cnt);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_uart_interface
